// File: rtl/ccg_lut_eval_pipe.sv
// Truth-table evaluator with self-sweep and MISR; a vector accepted at edge t is consumable at edge t+LAT.
// Backpressure: out_valid && !out_ready freezes every stage and deasserts in_ready; tables are writable only when idle.
module ccg_lut_eval_pipe #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 17,
  parameter int LAT   = 2,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
  localparam int AW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int NV = 1 << N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [NV-1:0]    cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  input  logic             sig_clr,
  output logic [SIG_W-1:0] sig,
  output logic [31:0]      vec_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [N_IN-1:0]  cnt;
  logic [NV-1:0]    tbl [N_OUT];
  logic [LAT-1:0]   vld;
  logic [N_OUT-1:0] dat [LAT];
  logic [N_OUT-1:0] lut;
  logic [N_IN-1:0]  x_sel;
  logic             stall, idle, in_hs, out_hs, inject, cfg_ok, last_hs;

  assign out_valid  = vld[LAT-1];
  assign f          = dat[LAT-1];
  assign stall      = out_valid && !out_ready;
  assign sweep_busy = (state != S_IDLE);
  assign in_ready   = !stall && !sweep_busy && !sweep_start;
  assign idle       = (vld == '0) && !sweep_busy;
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign inject     = in_hs || ((state == S_GEN) && !stall);
  assign x_sel      = (state == S_GEN) ? cnt : x;
  assign cfg_ok     = cfg_we && idle && !in_hs && !sweep_start && (cfg_addr < AW'(N_OUT));
  // Sweep never leaves bubbles ahead of the last vector, so it is last when it is the only one in flight.
  assign last_hs    = (state == S_DRAIN) && out_hs && ((vld & ~(LAT'(1) << (LAT - 1))) == '0);

  always_comb begin
    lut = '0;
    for (int j = 0; j < N_OUT; j++) lut[j] = tbl[j][x_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) tbl[j] <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_ok) tbl[cfg_addr] <= cfg_data;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else if (!stall) begin
      vld[0] <= inject;
      if (inject) dat[0] <= lut;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: if (sweep_start && idle) begin
          state <= S_GEN;
          cnt   <= '0;
        end
        S_GEN: if (!stall) begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= S_DRAIN;
        end
        S_DRAIN: if (last_hs) begin
          state      <= S_IDLE;
          sweep_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a same-cycle handshake; the vector is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig     <= '0;
      vec_cnt <= '0;
    end else if (sig_clr) begin
      sig     <= '0;
      vec_cnt <= '0;
    end else if (out_hs) begin
      sig     <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(f);
      vec_cnt <= vec_cnt + 32'd1;
    end
  end

endmodule
